// File: rtl/ddr3_axi_memtest.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_axi_memtest
//  Purpose  : Self-contained AXI4 memory test master. A start pulse writes
//             NUM_BURSTS bursts of BURST_LEN 32-bit beats from BASE_ADDR,
//             then reads them back and counts every bad beat or response.
//  Ports    : clk_i, rst_i (sync, active-high), start_i
//             busy_o, done_o, errors_o[15:0] (saturating)
//             AXI write address : outport_awvalid_o/awready_i, awaddr_o, awlen_o
//             AXI write data    : outport_wvalid_o/wready_i, wdata_o, wlast_o
//             AXI write resp    : outport_bvalid_i/bready_o, bresp_i
//             AXI read address  : outport_arvalid_o/arready_i, araddr_o, arlen_o
//             AXI read data     : outport_rvalid_i/rready_o, rdata_i, rresp_i,
//                                 rlast_i
//  Options  : MEMTEST_LFSR_EN - when defined the data pattern is a 32-bit
//             Galois LFSR (x^32+x^22+x^2+x+1, seed 32'hACE1_0001) instead of
//             the byte address of each beat.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr3_axi_memtest #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_BURSTS = 16,
  parameter int          BURST_LEN  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] errors_o,
  // write address channel
  output logic        outport_awvalid_o,
  input  logic        outport_awready_i,
  output logic [31:0] outport_awaddr_o,
  output logic [7:0]  outport_awlen_o,
  // write data channel
  output logic        outport_wvalid_o,
  input  logic        outport_wready_i,
  output logic [31:0] outport_wdata_o,
  output logic        outport_wlast_o,
  // write response channel
  input  logic        outport_bvalid_i,
  output logic        outport_bready_o,
  input  logic [1:0]  outport_bresp_i,
  // read address channel
  output logic        outport_arvalid_o,
  input  logic        outport_arready_i,
  output logic [31:0] outport_araddr_o,
  output logic [7:0]  outport_arlen_o,
  // read data channel
  input  logic        outport_rvalid_i,
  output logic        outport_rready_o,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic        outport_rlast_i
);

  localparam logic [7:0]  c_last_beat   = 8'(BURST_LEN - 1);
  localparam logic [15:0] c_last_burst  = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] c_burst_bytes = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [15:0] r_burst;
  logic [7:0]  r_beat;
  logic [31:0] r_burst_addr;
  logic [15:0] r_errors;

  logic        w_start;
  logic        w_wbeat_acc;
  logic        w_rbeat_acc;
  logic        w_bresp_acc;
  logic        w_beat_last;
  logic        w_burst_last;
  logic        w_burst_end;
  logic        w_phase_end;
  logic        w_rd_bad;
  logic        w_err_inc;
  logic [31:0] w_pattern;

  assign w_beat_last  = (r_beat == c_last_beat);
  assign w_burst_last = (r_burst == c_last_burst);
  // A burst closes on its write response or on the last counted read beat;
  // rlast_i is only checked, never trusted to terminate the burst.
  assign w_burst_end  = w_bresp_acc || (w_rbeat_acc && w_beat_last);
  assign w_phase_end  = w_burst_end && w_burst_last;

  // --------------------------------------------------------------------------
  // Data pattern generation
  // --------------------------------------------------------------------------
`ifdef MEMTEST_LFSR_EN
  localparam logic [31:0] c_lfsr_seed = 32'hACE1_0001;
  localparam logic [31:0] c_lfsr_taps = 32'h8020_0003;

  logic [31:0] r_lfsr;

  // Reseeded when the write phase starts and again when the read phase
  // starts, so the read expectation replays the exact write sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= c_lfsr_seed;
    end else if (w_start || (w_bresp_acc && w_burst_last)) begin
      r_lfsr <= c_lfsr_seed;
    end else if (w_wbeat_acc || w_rbeat_acc) begin
      r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 32'h0);
    end
  end

  assign w_pattern = r_lfsr;
`else
  // Byte address of the current beat; identical for write and read phase.
  assign w_pattern = r_burst_addr + {22'b0, r_beat, 2'b00};
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx        = r_state;
    w_start           = 1'b0;
    w_wbeat_acc       = 1'b0;
    w_rbeat_acc       = 1'b0;
    w_bresp_acc       = 1'b0;
    outport_awvalid_o = 1'b0;
    outport_wvalid_o  = 1'b0;
    outport_bready_o  = 1'b0;
    outport_arvalid_o = 1'b0;
    outport_rready_o  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_start    = 1'b1;
          w_state_nx = S_WR_ADDR;
        end
      end
      S_WR_ADDR: begin
        outport_awvalid_o = 1'b1;
        if (outport_awready_i) begin
          w_state_nx = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        outport_wvalid_o = 1'b1;
        if (outport_wready_i) begin
          w_wbeat_acc = 1'b1;
          if (w_beat_last) begin
            w_state_nx = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        outport_bready_o = 1'b1;
        if (outport_bvalid_i) begin
          w_bresp_acc = 1'b1;
          w_state_nx  = w_burst_last ? S_RD_ADDR : S_WR_ADDR;
        end
      end
      S_RD_ADDR: begin
        outport_arvalid_o = 1'b1;
        if (outport_arready_i) begin
          w_state_nx = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        outport_rready_o = 1'b1;
        if (outport_rvalid_i) begin
          w_rbeat_acc = 1'b1;
          if (w_beat_last) begin
            w_state_nx = w_burst_last ? S_DONE : S_RD_ADDR;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst / beat counters and error accumulation
  // --------------------------------------------------------------------------
  assign w_rd_bad  = (outport_rdata_i != w_pattern)
                  || (outport_rresp_i != 2'b00)
                  || (outport_rlast_i != w_beat_last);
  assign w_err_inc = (w_bresp_acc && (outport_bresp_i != 2'b00))
                  || (w_rbeat_acc && w_rd_bad);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_burst      <= 16'd0;
      r_beat       <= 8'd0;
      r_burst_addr <= BASE_ADDR;
      r_errors     <= 16'd0;
    end else if (w_start) begin
      r_burst      <= 16'd0;
      r_beat       <= 8'd0;
      r_burst_addr <= BASE_ADDR;
      r_errors     <= 16'd0;
    end else begin
      if (w_wbeat_acc || w_rbeat_acc) begin
        r_beat <= w_beat_last ? 8'd0 : r_beat + 8'd1;
      end
      if (w_phase_end) begin
        r_burst      <= 16'd0;
        r_burst_addr <= BASE_ADDR;
      end else if (w_burst_end) begin
        r_burst      <= r_burst + 16'd1;
        r_burst_addr <= r_burst_addr + c_burst_bytes;
      end
      // Saturate rather than wrap so a huge failure count never reads as clean.
      if (w_err_inc && (r_errors != 16'hFFFF)) begin
        r_errors <= r_errors + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all payloads come from registers only, so they hold steady for
  // as long as the matching valid waits on a ready.
  // --------------------------------------------------------------------------
  assign busy_o           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o           = (r_state == S_DONE);
  assign errors_o         = r_errors;
  assign outport_awaddr_o = r_burst_addr;
  assign outport_awlen_o  = c_last_beat;
  assign outport_araddr_o = r_burst_addr;
  assign outport_arlen_o  = c_last_beat;
  assign outport_wdata_o  = w_pattern;
  assign outport_wlast_o  = (r_state == S_WR_DATA) && w_beat_last;

endmodule
`default_nettype wire
